// File: rtl/stream_sequencer_pkg.sv
// Shared types and defaults for the two-source stream sequencer.
// State encoding is 8 bits wide to match the rest of the codebase.
package stream_sequencer_pkg;

    localparam int FLUSH_CYCLES_DEF = 4;

    typedef enum logic [7:0] {
        ST_IDLE  = 8'h00,
        ST_FLUSH = 8'h01,
        ST_PLAY  = 8'h02,
        ST_DONE  = 8'h03
    } state_t;

    // Lowest-index enabled source; only meaningful when en != 0.
    function automatic logic first_src(input logic [1:0] en);
        return en[0] ? 1'b0 : 1'b1;
    endfunction

endpackage

// File: rtl/stream_src_mux.sv
// Combinational steering between the two source FIFOs and the splitter.
// Read strobes and flags are zero-latency; data follows the source read by one cycle.
module stream_src_mux (
    input  logic       i_play,
    input  logic       i_clk_en,
    input  logic       i_sel,
    input  logic       i_data_sel,
    input  logic       i_data_vld,
    input  logic [7:0] i_src0_data,
    input  logic [7:0] i_src1_data,
    input  logic       i_src0_empty,
    input  logic       i_src1_empty,
    input  logic       i_src0_end,
    input  logic       i_src1_end,
    input  logic       i_split_rd,
    output logic       o_src0_rd,
    output logic       o_src1_rd,
    output logic [7:0] o_split_data,
    output logic       o_split_empty,
    output logic       o_split_end_in
);

    logic w_rd;

    assign w_rd           = i_play & i_clk_en & i_split_rd;
    assign o_src0_rd      = w_rd & ~i_sel;
    assign o_src1_rd      = w_rd &  i_sel;
    assign o_split_empty  = i_play ? (i_sel ? i_src1_empty : i_src0_empty) : 1'b1;
    assign o_split_end_in = i_play & (i_sel ? i_src1_end : i_src0_end);
    // Data is muxed by the source that was actually read, and blanked until a read lands.
    assign o_split_data   = i_data_vld ? (i_data_sel ? i_src1_data : i_src0_data) : 8'h00;

endmodule

// File: rtl/stream_sequencer.sv
// Plays enabled byte sources into a splitter one after another, holding the
// splitter in reset for FLUSH_CYCLES enabled cycles before each source.
module stream_sequencer
    import stream_sequencer_pkg::*;
#(
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clk_en,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic        i_loop,
    input  logic [1:0]  i_src_en,
    input  logic [7:0]  i_src0_data,
    input  logic [7:0]  i_src1_data,
    input  logic        i_src0_empty,
    input  logic        i_src1_empty,
    input  logic        i_src0_end,
    input  logic        i_src1_end,
    output logic        o_src0_rd,
    output logic        o_src1_rd,
    output logic [7:0]  o_split_data,
    output logic        o_split_empty,
    output logic        o_split_end_in,
    input  logic        i_split_rd,
    input  logic        i_split_end,
    output logic        o_split_rst,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_cur_src,
    output logic [31:0] o_byte_count
);

    localparam logic [3:0] LP_FLUSH_LD = 4'(FLUSH_CYCLES - 1);

    state_t      r_state;
    logic        r_cur_src;
    logic        r_rd_src;
    logic        r_data_vld;
    logic [3:0]  r_flush_cnt;
    logic [31:0] r_byte_count;
    logic        r_busy;
    logic        r_done;
    logic        r_split_rst;

    logic        w_play;
    logic        w_rd_any;
    logic        w_accept;

    assign w_play   = (r_state == ST_PLAY);
    assign w_rd_any = o_src0_rd | o_src1_rd;
    assign w_accept = w_play & i_split_rd & ~o_split_empty;

    stream_src_mux u_mux (
        .i_play         (w_play),
        .i_clk_en       (i_clk_en),
        .i_sel          (r_cur_src),
        .i_data_sel     (r_rd_src),
        .i_data_vld     (r_data_vld),
        .i_src0_data    (i_src0_data),
        .i_src1_data    (i_src1_data),
        .i_src0_empty   (i_src0_empty),
        .i_src1_empty   (i_src1_empty),
        .i_src0_end     (i_src0_end),
        .i_src1_end     (i_src1_end),
        .i_split_rd     (i_split_rd),
        .o_src0_rd      (o_src0_rd),
        .o_src1_rd      (o_src1_rd),
        .o_split_data   (o_split_data),
        .o_split_empty  (o_split_empty),
        .o_split_end_in (o_split_end_in)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= ST_IDLE;
            r_cur_src    <= 1'b0;
            r_rd_src     <= 1'b0;
            r_data_vld   <= 1'b0;
            r_flush_cnt  <= 4'd0;
            r_byte_count <= 32'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_split_rst  <= 1'b0;
        end else if (i_clk_en) begin
            r_data_vld <= w_rd_any;
            if (w_rd_any)
                r_rd_src <= r_cur_src;
            if (w_accept && r_byte_count != 32'hFFFF_FFFF)
                r_byte_count <= r_byte_count + 32'd1;

            if (i_abort) begin
                r_state     <= ST_IDLE;
                r_busy      <= 1'b0;
                r_done      <= 1'b0;
                r_split_rst <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (i_start) begin
                            r_byte_count <= 32'd0;
                            if (i_src_en == 2'b00) begin
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state     <= ST_FLUSH;
                                r_cur_src   <= first_src(i_src_en);
                                r_flush_cnt <= LP_FLUSH_LD;
                                r_busy      <= 1'b1;
                                r_done      <= 1'b0;
                            end
                        end
                    end
                    ST_FLUSH: begin
                        if (r_flush_cnt == 4'd0) begin
                            r_state     <= ST_PLAY;
                            r_split_rst <= 1'b1;
                        end else begin
                            r_flush_cnt <= r_flush_cnt - 4'd1;
                        end
                    end
                    ST_PLAY: begin
                        if (i_split_end) begin
                            r_split_rst <= 1'b0;
                            if (!r_cur_src && i_src_en[1]) begin
                                r_state     <= ST_FLUSH;
                                r_cur_src   <= 1'b1;
                                r_flush_cnt <= LP_FLUSH_LD;
                            end else if (i_loop && i_src_en != 2'b00) begin
                                r_state     <= ST_FLUSH;
                                r_cur_src   <= first_src(i_src_en);
                                r_flush_cnt <= LP_FLUSH_LD;
                            end else begin
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b0;
                        r_split_rst <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_split_rst  = r_split_rst;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_cur_src    = r_cur_src;
    assign o_byte_count = r_byte_count;

endmodule

// File: tb/tb_stream_sequencer.sv
// Randomized bench: source FIFOs and splitter are queue models; expected byte
// stream is the enabled sources' contents concatenated in index order.
module tb_stream_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en, start, abort, loop_i;
    logic [1:0]  src_en;
    logic [7:0]  src0_data, src1_data;
    logic        src0_empty, src1_empty, src0_end, src1_end;
    logic        src0_rd, src1_rd;
    logic [7:0]  split_data;
    logic        split_empty, split_end_in, split_rd, split_end, split_rst;
    logic        busy, done, cur_src;
    logic [31:0] byte_count;

    always #5 clk = ~clk;

    // Splitter model: stream ends once it is out of reset and the source is drained.
    assign split_end = split_rst & split_empty & split_end_in;

    stream_sequencer #(.FLUSH_CYCLES(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_start(start), .i_abort(abort),
        .i_loop(loop_i), .i_src_en(src_en),
        .i_src0_data(src0_data), .i_src1_data(src1_data),
        .i_src0_empty(src0_empty), .i_src1_empty(src1_empty),
        .i_src0_end(src0_end), .i_src1_end(src1_end),
        .o_src0_rd(src0_rd), .o_src1_rd(src1_rd),
        .o_split_data(split_data), .o_split_empty(split_empty), .o_split_end_in(split_end_in),
        .i_split_rd(split_rd), .i_split_end(split_end), .o_split_rst(split_rst),
        .o_busy(busy), .o_done(done), .o_cur_src(cur_src), .o_byte_count(byte_count)
    );

    int n_cmp = 0, n_bad = 0;
    byte unsigned q0[$], q1[$], got[$], exp_q[$];
    int n_rd_off, n_excl, n_flush, n_reads, n_rd_total;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock cycle, entered and left at a negedge. rdm: 0 no read, 1 random read, 2 forced read.
    task automatic cyc(input bit ce, input bit st, input bit ab, input int rdm);
        logic r0, r1;
        clk_en = ce; start = st; abort = ab;
        case (rdm)
            1:       split_rd = ce && !split_empty && ($urandom_range(0, 3) != 0);
            2:       split_rd = ce;
            default: split_rd = 1'b0;
        endcase
        #1;
        if (!ce && (src0_rd || src1_rd)) n_rd_off++;
        if (busy && done) n_excl++;
        if (ce && busy && !split_rst) n_flush++;
        if (split_rd && !split_empty) n_reads++;
        r0 = src0_rd; r1 = src1_rd;
        n_rd_total += int'(r0) + int'(r1);
        @(posedge clk); #1;
        if (r0 && q0.size() > 0) src0_data = q0.pop_front();
        if (r1 && q1.size() > 0) src1_data = q1.pop_front();
        src0_empty = (q0.size() == 0);
        src1_empty = (q1.size() == 0);
        @(negedge clk);
        if (r0 || r1) got.push_back(split_data);
    endtask

    task automatic load(input int l0, input int l1);
        q0.delete(); q1.delete(); got.delete(); exp_q.delete();
        for (int i = 0; i < l0; i++) q0.push_back(byte'($urandom_range(0, 255)));
        for (int i = 0; i < l1; i++) q1.push_back(byte'($urandom_range(0, 255)));
        src0_empty = (q0.size() == 0);
        src1_empty = (q1.size() == 0);
        n_rd_off = 0; n_excl = 0; n_flush = 0; n_reads = 0; n_rd_total = 0;
    endtask

    task automatic cmp_bytes(input string tag);
        chk({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), (i < got.size()) ? 32'(got[i]) : 32'hDEAD_BEEF, 32'(exp_q[i]));
    endtask

    // tog: 0 clk_en always 1, 1 alternating, 2 random.
    task automatic run_seq(input string tag, input int l0, input int l1, input logic [1:0] en, input int tog);
        int  guard;
        bit  ce;
        load(l0, l1);
        if (en[0]) foreach (q0[i]) exp_q.push_back(q0[i]);
        if (en[1]) foreach (q1[i]) exp_q.push_back(q1[i]);
        loop_i = 1'b0; src_en = en;
        cyc(1'b1, 1'b1, 1'b0, 0);
        guard = 0; ce = 1'b1;
        while (!done && guard < 3000) begin
            ce = (tog == 0) ? 1'b1 : (tog == 1) ? ~ce : 1'($urandom_range(0, 1));
            cyc(ce, 1'b0, 1'b0, 1);
            guard++;
        end
        if (guard >= 3000) chk({tag, "_timeout"}, 32'd0, 32'd1);
        cmp_bytes(tag);
        chk({tag, "_count"}, byte_count, exp_q.size());
        chk({tag, "_count_rd"}, byte_count, n_reads);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_cur"}, cur_src, en[1] ? 1'b1 : 1'b0);
        chk({tag, "_flush"}, n_flush, 4 * (int'(en[0]) + int'(en[1])));
        chk({tag, "_rd_off"}, n_rd_off, 0);
        chk({tag, "_excl"}, n_excl, 0);
    endtask

    initial begin
        int guard, cnt, snap, rises, done_seen;
        logic prev;
        rst = 1'b0; clk_en = 1'b1; start = 1'b1; abort = 1'b0; loop_i = 1'b0; src_en = 2'b11;
        src0_data = 8'hA5; src1_data = 8'h5A; src0_empty = 1'b0; src1_empty = 1'b0;
        src0_end = 1'b1; src1_end = 1'b1; split_rd = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_split_rst", split_rst, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rd0", src0_rd, 1'b0);
        chk("rst_rd1", src1_rd, 1'b0);
        chk("rst_empty", split_empty, 1'b1);
        chk("rst_end_in", split_end_in, 1'b0);
        chk("rst_data", split_data, 8'h00);
        chk("rst_cur", cur_src, 1'b0);
        chk("rst_count", byte_count, 32'd0);
        start = 1'b0; split_rd = 1'b0; src0_empty = 1'b1; src1_empty = 1'b1;
        rst = 1'b1;
        @(negedge clk);

        run_seq("single10", 10, 0, 2'b01, 0);
        run_seq("both5_7", 5, 7, 2'b11, 0);
        run_seq("toggle10", 10, 0, 2'b01, 1);
        for (int r = 0; r < 6; r++)
            run_seq($sformatf("rnd%0d", r), $urandom_range(1, 12), $urandom_range(1, 12),
                    2'($urandom_range(1, 3)), r % 3);

        // No sources enabled: straight to DONE, never any read.
        load(4, 4);
        src_en = 2'b00;
        cyc(1'b1, 1'b1, 1'b0, 0);
        chk("none_done", done, 1'b1);
        chk("none_busy", busy, 1'b0);
        repeat (5) cyc(1'b1, 1'b0, 1'b0, 2);
        chk("none_rd", n_rd_total, 0);
        chk("none_count", byte_count, 32'd0);

        // Abort in the middle of source 1.
        load(3, 10);
        src_en = 2'b11;
        cyc(1'b1, 1'b1, 1'b0, 0);
        guard = 0;
        while (!(cur_src && split_rst && got.size() >= 5) && guard < 500) begin
            cyc(1'b1, 1'b0, 1'b0, 1);
            guard++;
        end
        chk("abort_reach", guard < 500, 1'b1);
        cnt = n_reads;
        cyc(1'b1, 1'b1, 1'b1, 0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_split_rst", split_rst, 1'b0);
        chk("abort_count", byte_count, cnt);
        snap = n_rd_total;
        repeat (10) cyc(1'b1, 1'b0, 1'b0, 2);
        chk("abort_no_rd", n_rd_total, snap);
        chk("abort_count_hold", byte_count, cnt);

        // Looping on source 1 only: flush/play repeats, never done.
        load(0, 4);
        foreach (q1[i]) exp_q.push_back(q1[i]);
        src_en = 2'b10; loop_i = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 0);
        rises = 0; done_seen = 0; prev = split_rst; guard = 0;
        while (rises < 3 && guard < 500) begin
            cyc(1'b1, 1'b0, 1'b0, 1);
            if (split_rst && !prev) rises++;
            prev = split_rst;
            if (done) done_seen++;
            guard++;
        end
        chk("loop_rises", rises, 3);
        chk("loop_flush", n_flush, 12);
        chk("loop_done", done_seen, 0);
        chk("loop_cur", cur_src, 1'b1);
        cmp_bytes("loop");
        cyc(1'b1, 1'b0, 1'b1, 0);
        chk("loop_abort", busy, 1'b0);
        loop_i = 1'b0;

        // Asynchronous reset while a read strobe is active.
        load(20, 0);
        src_en = 2'b01;
        cyc(1'b1, 1'b1, 1'b0, 0);
        guard = 0;
        while (!split_rst && guard < 50) begin
            cyc(1'b1, 1'b0, 1'b0, 0);
            guard++;
        end
        clk_en = 1'b1; split_rd = 1'b1;
        #1;
        chk("arst_pre_rd", src0_rd, 1'b1);
        rst = 1'b0;
        #1;
        chk("arst_rd0", src0_rd, 1'b0);
        chk("arst_rd1", src1_rd, 1'b0);
        chk("arst_split_rst", split_rst, 1'b0);
        chk("arst_count", byte_count, 32'd0);
        @(posedge clk); #1;
        chk("arst_rd_hold", src0_rd, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stream_sequencer.md
STREAM_SEQUENCER -- requirements
Module: stream_sequencer

Interface
REQ-001 Parameter FLUSH_CYCLES, default 4, number of cycles the splitter is held in reset between sources (legal range 2..15).
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 clk_en  input  1  global clock enable; state, counters and status advance only when high.
REQ-005 start  input  1  begin sequencing from the lowest-index enabled source (sampled when clk_en high).
REQ-006 abort  input  1  return to IDLE immediately (sampled when clk_en high).
REQ-007 loop  input  1  after the last enabled source, wrap to the first enabled source instead of finishing.
REQ-008 src_en  input  2  per-source enable; bit n enables source n; sampled at each source-selection decision.
REQ-009 src0_data / src1_data  input  8  source FIFO read data, valid the cycle after the read.
REQ-010 src0_empty / src1_empty  input  1  source FIFO empty.
REQ-011 src0_end / src1_end  input  1  source has no further bytes beyond its FIFO contents.
REQ-012 src0_rd / src1_rd  output  1  source FIFO read strobe.
REQ-013 split_data  output  8  byte stream to the splitter stream input.
REQ-014 split_empty  output  1  empty flag to the splitter.
REQ-015 split_end_in  output  1  end-of-stream flag to the splitter.
REQ-016 split_rd  input  1  read strobe from the splitter (already qualified by clk_en).
REQ-017 split_end  input  1  splitter end-of-stream output; the current source is fully consumed.
REQ-018 split_rst  output  1  synchronous active-low reset to the splitter.
REQ-019 busy / done  output  1  sequencing in progress / sequence finished.
REQ-020 cur_src  output  1  index of the selected source.
REQ-021 byte_count  output  32  bytes delivered to the splitter since the last start.

Function
REQ-022 The FSM SHALL have the states IDLE, FLUSH, PLAY and DONE.
REQ-023 IDLE: split_rst=0, busy=0, done=0; on start go to FLUSH with cur_src = lowest enabled source, or to DONE if src_en==0.
REQ-024 FLUSH: split_rst=0, both srcN_rd=0, split_empty=1, split_end_in=0; the flush counter loads FLUSH_CYCLES-1 on entry and decrements on clk_en; at 0 the FSM goes to PLAY.
REQ-025 PLAY: split_rst=1, busy=1; split_data = src[cur_src]_data; split_empty = src[cur_src]_empty; split_end_in = src[cur_src]_end; src[cur_src]_rd = split_rd; the other source's rd = 0.
REQ-026 src_rd, split_empty and split_end_in SHALL be combinational (zero latency). split_data SHALL be muxed by cur_src registered at the read, so data follows the source read latency of one cycle.
REQ-027 In PLAY, when split_end=1 and clk_en=1, the next source SHALL be selected as follows:
  - next enabled source with index > cur_src -> FLUSH;
  - else if loop=1 and any source enabled -> FLUSH on the lowest enabled source;
  - else -> DONE.
REQ-028 DONE: split_rst=0, done=1, busy=0; start -> same behaviour as start in IDLE.
REQ-029 byte_count SHALL clear on an accepted start, increment on split_rd && ~split_empty in PLAY, and saturate at 32'hFFFFFFFF.
REQ-030 abort SHALL force IDLE from any state on the next enabled edge; abort and start together -> abort wins.
REQ-031 With clk_en=0, all registers SHALL hold and both srcN_rd SHALL be 0.
REQ-032 busy and done are never both 1.

Reset
REQ-033 While rst=0, outputs SHALL be:
  - state=IDLE, cur_src=0, byte_count=0, flush counter=0;
  - split_rst=0, busy=0, done=0, src0_rd=0, src1_rd=0, split_empty=1, split_end_in=0, split_data=0.
REQ-034 Reset mid-PLAY SHALL drop all rd strobes asynchronously, with no further source reads.

Structure
REQ-035 Shared package: the FSM state encoding (8-bit, matching the codebase's state width) and the FLUSH_CYCLES default.
REQ-036 Single module; no sub-module required. The source mux MAY be factored as stream_src_mux.

Verification
REQ-037 Source 0 holds 10 bytes with end, src_en=01, start: split_rst low for 4 cycles; 10 bytes delivered in order; byte_count=10; done=1 after split_end.
REQ-038 Both sources enabled with 5 and 7 bytes, loop=0: source 0 bytes, then a 4-cycle flush with split_rst=0, then source 1 bytes; byte_count=12; cur_src ends at 1.
REQ-039 src_en=00, start: DONE on the next edge; no rd pulses ever.
REQ-040 abort in mid-PLAY of source 1: IDLE on the next edge; src1_rd=0 thereafter; byte_count holds its value.
REQ-041 loop=1, src_en=10: after split_end, FLUSH then PLAY again on source 1; done stays 0.
REQ-042 clk_en toggling 1/0 during PLAY: byte sequence identical to the clk_en=1 case; no rd while clk_en=0.
